// File: rtl/sae_pkg.sv
// Shared constants and types for the SAE responder: modulus, plaintext
// alphabet bounds, request modes and FSM states.
package sae_pkg;

  localparam int unsigned N        = 227;
  localparam logic [7:0]  N8       = 8'(N);
  localparam logic [7:0]  PTXT_MIN = 8'h61;
  localparam logic [7:0]  PTXT_MAX = 8'h7A;

  typedef enum logic [1:0] {
    MODE_NOP    = 2'b00,
    MODE_KEYGEN = 2'b01,
    MODE_ENC    = 2'b10,
    MODE_DEC    = 2'b11
  } sae_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } sae_state_t;

  // Keys, public or private, must lie in 1..N-1.
  function automatic logic key_in_range(input logic [7:0] k);
    return (k != 8'h00) && (k < N8);
  endfunction

endpackage

// File: rtl/sae_mod_add.sv
// Combinational (a + b) mod N for operands already known to be below N,
// so a single conditional subtraction is enough.
module sae_mod_add
  import sae_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_sum
);

  logic [8:0] w_sum;
  logic [8:0] w_wrapped;

  assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
  assign w_wrapped = w_sum - 9'(N);
  assign o_sum     = (w_sum >= 9'(N)) ? w_wrapped[7:0] : w_sum[7:0];

endmodule

// File: rtl/sae_engine.sv
// SAE responder: captures one keygen/encrypt/decrypt request in IDLE,
// validates and computes in EXEC, and presents registered results in DONE.
module sae_engine
  import sae_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [7:0] data_input,
  input  logic [7:0] key_input,
  input  logic       inputs_valid,
  output logic       busy,
  output logic [7:0] data_output,
  output logic       output_ready,
  output logic       err_invalid_ptxt_char,
  output logic       err_invalid_seckey,
  output logic       err_invalid_ctxt_char
);

  sae_state_t r_state;
  sae_state_t w_next_state;
  logic       w_accept;

  sae_mode_t  r_mode;
  logic [7:0] r_data;
  logic [7:0] r_key;

  logic [7:0] r_data_output;
  logic       r_output_ready;
  logic       r_err_ptxt;
  logic       r_err_key;
  logic       r_err_ctxt;

  logic [7:0] w_sum;
  logic [7:0] w_result;
  logic       w_err_ptxt;
  logic       w_err_key;
  logic       w_err_ctxt;
  logic       w_any_err;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: defaults first so no path through the case leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (inputs_valid && (mode != MODE_NOP)) begin
          w_accept     = 1'b1;
          w_next_state = EXEC;
        end
      end
      EXEC:    w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_NOP;
      r_data <= 8'h00;
      r_key  <= 8'h00;
    end else if (w_accept) begin
      r_mode <= sae_mode_t'(mode);
      r_data <= data_input;
      r_key  <= key_input;
    end
  end

  // Encrypt adds the public key, decrypt adds the private key: same adder.
  sae_mod_add u_mod_add (
    .i_a   (r_data),
    .i_b   (r_key),
    .o_sum (w_sum)
  );

  assign w_err_key  = !key_in_range(r_key);
  assign w_err_ptxt = (r_mode == MODE_ENC) &&
                      ((r_data < PTXT_MIN) || (r_data > PTXT_MAX));
  assign w_err_ctxt = (r_mode == MODE_DEC) && (r_data >= N8);
  assign w_any_err  = w_err_key | w_err_ptxt | w_err_ctxt;
  assign w_result   = (r_mode == MODE_KEYGEN) ? (N8 - r_key) : w_sum;

  // Pulses are written only on the EXEC->DONE edge and cleared on every
  // other edge; data_output keeps its last value until the next EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_output  <= 8'h00;
      r_output_ready <= 1'b0;
      r_err_ptxt     <= 1'b0;
      r_err_key      <= 1'b0;
      r_err_ctxt     <= 1'b0;
    end else if (r_state == EXEC) begin
      r_data_output  <= w_any_err ? 8'h00 : w_result;
      r_output_ready <= !w_any_err;
      r_err_ptxt     <= w_err_ptxt;
      r_err_key      <= w_err_key;
      r_err_ctxt     <= w_err_ctxt;
    end else begin
      r_output_ready <= 1'b0;
      r_err_ptxt     <= 1'b0;
      r_err_key      <= 1'b0;
      r_err_ctxt     <= 1'b0;
    end
  end

  assign busy                  = (r_state != IDLE);
  assign data_output           = r_data_output;
  assign output_ready          = r_output_ready;
  assign err_invalid_ptxt_char = r_err_ptxt;
  assign err_invalid_seckey    = r_err_key;
  assign err_invalid_ctxt_char = r_err_ctxt;

endmodule

// File: tb/tb_sae_engine.sv
// Directed bench for sae_engine: hand-computed vectors for each mode, error
// flags, strobe spacing, no-op strobes and asynchronous reset.
module tb_sae_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] data_input;
  logic [7:0] key_input;
  logic       inputs_valid;
  logic       busy;
  logic [7:0] data_output;
  logic       output_ready;
  logic       err_invalid_ptxt_char;
  logic       err_invalid_seckey;
  logic       err_invalid_ctxt_char;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sae_engine dut (
    .clk                   (clk),
    .rst                   (rst),
    .mode                  (mode),
    .data_input            (data_input),
    .key_input             (key_input),
    .inputs_valid          (inputs_valid),
    .busy                  (busy),
    .data_output           (data_output),
    .output_ready          (output_ready),
    .err_invalid_ptxt_char (err_invalid_ptxt_char),
    .err_invalid_seckey    (err_invalid_seckey),
    .err_invalid_ctxt_char (err_invalid_ctxt_char)
  );

  // Flags packed as {ready, ptxt, seckey, ctxt} for compact comparison.
  function automatic logic [3:0] flags();
    return {output_ready, err_invalid_ptxt_char, err_invalid_seckey, err_invalid_ctxt_char};
  endfunction

  // Strobes one request at a negedge; returns 1 time unit after the t0+1 edge.
  task automatic send(input logic [1:0] m, input logic [7:0] d, input logic [7:0] k);
    @(negedge clk);
    mode = m; data_input = d; key_input = k; inputs_valid = 1'b1;
    @(posedge clk); #1;
    inputs_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Advances past the t0+2 edge.
  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b00; data_input = 8'h00; key_input = 8'h00; inputs_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, data_output, flags()} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b data=%h flags=%b, want all zero", busy, data_output, flags());
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_keygen();
    logic [7:0] keys [2] = '{8'h01, 8'hE2};
    logic [7:0] exps [2] = '{8'hE2, 8'h01};
    for (int i = 0; i < 2; i++) begin
      send(2'b01, 8'h55, keys[i]);
      checks++;
      if (data_output !== exps[i] || flags() !== 4'b1000) begin
        errors++;
        $display("FAIL keygen_%0d: got data=%h flags=%b, want data=%h flags=1000", i, data_output, flags(), exps[i]);
      end
      settle();
      checks++;
      if (busy !== 1'b0 || flags() !== 4'b0000 || data_output !== exps[i]) begin
        errors++;
        $display("FAIL keygen_hold_%0d: got busy=%b flags=%b data=%h, want busy=0 flags=0000 data=%h", i, busy, flags(), data_output, exps[i]);
      end
    end
  endtask

  task automatic test_crypt();
    logic [1:0] modes [4] = '{2'b10, 2'b10, 2'b11, 2'b11};
    logic [7:0] dats  [4] = '{8'h61, 8'h7A, 8'h79, 8'h60};
    logic [7:0] keys  [4] = '{8'hE2, 8'hE2, 8'h01, 8'h01};
    logic [7:0] exps  [4] = '{8'h60, 8'h79, 8'h7A, 8'h61};
    for (int i = 0; i < 4; i++) begin
      send(modes[i], dats[i], keys[i]);
      checks++;
      if (data_output !== exps[i] || flags() !== 4'b1000) begin
        errors++;
        $display("FAIL crypt_%0d: got data=%h flags=%b, want data=%h flags=1000", i, data_output, flags(), exps[i]);
      end
      settle();
    end
  endtask

  task automatic test_errors();
    logic [1:0] modes [5] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b10};
    logic [7:0] dats  [5] = '{8'h41, 8'hE3, 8'h00, 8'h00, 8'h41};
    logic [7:0] keys  [5] = '{8'hE2, 8'h01, 8'h00, 8'hE3, 8'h00};
    logic [3:0] expf  [5] = '{4'b0100, 4'b0001, 4'b0010, 4'b0010, 4'b0110};
    for (int i = 0; i < 5; i++) begin
      send(modes[i], dats[i], keys[i]);
      checks++;
      if (data_output !== 8'h00 || flags() !== expf[i]) begin
        errors++;
        $display("FAIL err_%0d: got data=%h flags=%b, want data=00 flags=%b", i, data_output, flags(), expf[i]);
      end
      settle();
      checks++;
      if (flags() !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse_%0d: got flags=%b busy=%b one cycle later, want 0000/0", i, flags(), busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ready_count = 0;
    logic exp_busy, exp_ready;
    @(negedge clk);
    mode = 2'b10; data_input = 8'h61; key_input = 8'hE2; inputs_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 8) inputs_valid = 1'b0;
      exp_busy  = (i <= 8) && (i % 3 != 2);
      exp_ready = (i <= 7) && (i % 3 == 1);
      if (output_ready) ready_count++;
      checks++;
      if (busy !== exp_busy || output_ready !== exp_ready) begin
        errors++;
        $display("FAIL b2b_cycle_%0d: got busy=%b ready=%b, want busy=%b ready=%b", i, busy, output_ready, exp_busy, exp_ready);
      end
    end
    checks++;
    if (ready_count != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, want 3", ready_count);
    end
    checks++;
    if (data_output !== 8'h60) begin
      errors++;
      $display("FAIL b2b_data: got %h, want 60", data_output);
    end
  endtask

  task automatic test_nop();
    @(negedge clk);
    mode = 2'b00; data_input = 8'h61; key_input = 8'h01; inputs_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || flags() !== 4'b0000) begin
        errors++;
        $display("FAIL nop_cycle_%0d: got busy=%b flags=%b, want 0/0000", i, busy, flags());
      end
    end
    inputs_valid = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    mode = 2'b01; data_input = 8'h00; key_input = 8'h05; inputs_valid = 1'b1;
    @(posedge clk); #1;
    inputs_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_busy: got busy=%b, want 1", busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, data_output, flags()} !== 13'h0) begin
      errors++;
      $display("FAIL rst_immediate: got busy=%b data=%h flags=%b, want all zero", busy, data_output, flags());
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, data_output, flags()} !== 13'h0) begin
        errors++;
        $display("FAIL rst_hold_%0d: got busy=%b data=%h flags=%b, want all zero", i, busy, data_output, flags());
      end
    end
    @(negedge clk); rst = 1'b0;
    send(2'b01, 8'h00, 8'h05);
    checks++;
    if (data_output !== 8'hDE || flags() !== 4'b1000) begin
      errors++;
      $display("FAIL rst_recover: got data=%h flags=%b, want data=de flags=1000", data_output, flags());
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_keygen();
    test_crypt();
    test_errors();
    test_back_to_back();
    test_nop();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
